// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences one MIPS32 instruction at a time through
// fetch / decode / execute / memory / writeback on a shared memory port and a
// single ALU, driving every datapath select and write enable.
//
//   state    | code | meaning
//   ---------+------+-----------------------------------------------
//   FETCH    |  0   | read instruction at PC, PC <= PC + 4 on ready
//   DECODE   |  1   | read registers, precompute branch target
//   MEMADR   |  2   | ALUOut <= A + sign-extended immediate
//   MEMRD    |  3   | read data memory at ALUOut
//   MEMWB    |  4   | write loaded data to rt
//   MEMWR    |  5   | write B to data memory at ALUOut
//   RTYPEEX  |  6   | ALU operation selected by funct
//   RTYPEWB  |  7   | write ALUOut to rd
//   BEQEX    |  8   | compare A and B, branch on zero
//   ADDIEX   |  9   | ALUOut <= A + sign-extended immediate
//   ADDIWB   |  10  | write ALUOut to rt
//   JEX      |  11  | PC <= jump target
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t state_q, state_d;
  // 1 = the instruction in flight is SW, 0 = LW; captured in DECODE
  logic   sw_sel_q, sw_sel_d;

  // Next-state selection; unused codes 12-15 recover to FETCH
  always_comb begin
    state_d  = state_q;
    sw_sel_d = sw_sel_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW: begin
            state_d  = S_MEMADR;
            sw_sel_d = 1'b0;
          end
          OP_SW: begin
            state_d  = S_MEMADR;
            sw_sel_d = 1'b1;
          end
          OP_RTYPE: state_d = S_RTYPEEX;
          OP_BEQ:   state_d = S_BEQEX;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JEX;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = sw_sel_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // State and LW/SW flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      sw_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sw_sel_q <= sw_sel_d;
    end
  end

  // Output decode from the current state. This is combinational rather than
  // registered because ir_write/pc_write/instr_done must follow mem_ready and
  // illegal_op must follow opcode within the same cycle, and everything must
  // drop to zero while rst is high.
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal_op = !((opcode == OP_LW)   || (opcode == OP_SW)  ||
                         (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                         (opcode == OP_ADDI)  || (opcode == OP_J));
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPEEX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RTYPEWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQEX: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          branch     = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JEX: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model (per-opcode
// state plans plus a per-state output table) is compared every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  logic [3:0] state;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {mem_req, iord, mem_write, ir_write, pc_write, branch,
                    pc_src, alu_src_a, alu_src_b, alu_op, reg_dst,
                    mem_to_reg, reg_write, instr_done, illegal_op};

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] base [16];
  int plan[$];
  int idx;

  function automatic logic [17:0] mk(input logic mreq, input logic io,
      input logic mw, input logic irw, input logic pcw, input logic br,
      input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic rd, input logic m2r, input logic rw);
    return {mreq, io, mw, irw, pcw, br, pcs, asa, asb, aop, rd, m2r, rw, 2'b00};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fetch_only();
    plan.delete();
    plan.push_back(0);
    plan.push_back(1);
    idx = 0;
  endtask

  task automatic load_plan(input logic [5:0] op);
    fetch_only();
    case (op)
      LW:   begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      SW:   begin plan.push_back(2); plan.push_back(5); end
      RT:   begin plan.push_back(6); plan.push_back(7); end
      BEQ:  plan.push_back(8);
      ADDI: begin plan.push_back(9); plan.push_back(10); end
      JMP:  plan.push_back(11);
      default: ;
    endcase
  endtask

  function automatic int model_state();
    return rst ? 0 : plan[idx];
  endfunction

  task automatic model_check();
    logic [17:0] e;
    int s;
    e = '0;
    if (!rst) begin
      s = plan[idx];
      e = base[s];
      if (s == 0) begin
        e[14] = mem_ready;
        e[13] = mem_ready;
      end
      if (s == 1 && !legal(opcode)) e[0] = 1'b1;
      if (idx == plan.size() - 1 && plan.size() > 2 && (s != 5 || mem_ready))
        e[1] = 1'b1;
    end
    chk("outputs", dut_vec, e);
    chk("state", state, model_state());
  endtask

  task automatic model_advance();
    int s;
    if (rst) begin
      fetch_only();
      return;
    end
    s = plan[idx];
    if ((s == 0 || s == 3 || s == 5) && !mem_ready) return;
    if (s == 1) begin
      load_plan(opcode);
      idx = (plan.size() > 2) ? 2 : 0;
    end else begin
      idx++;
      if (idx == plan.size()) fetch_only();
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic [5:0] op,
                      input int exp_s = -1);
    rst = r;
    mem_ready = mr;
    opcode = op;
    #1;
    model_check();
    if (exp_s >= 0) begin
      chk("lit_state", state, exp_s);
      chk("model_pin", model_state(), exp_s);
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) base[i] = '0;
    base[0]  = mk(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0);
    base[1]  = mk(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0);
    base[2]  = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0);
    base[3]  = mk(1,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0);
    base[4]  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1);
    base[5]  = mk(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0);
    base[6]  = mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0);
    base[7]  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1);
    base[8]  = mk(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0);
    base[9]  = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0);
    base[10] = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1);
    base[11] = mk(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0);
    fetch_only();

    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'd0;
    @(posedge clk);
    #1;

    // reset held with mem_ready high
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("rst_outs", dut_vec, 18'd0);
      step(1, 1, 6'd0, 0);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("fetch_release", dut_vec, mk(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0));

    // LW, no wait states
    step(0, 1, LW, 0);
    step(0, 1, LW, 1);
    step(0, 1, LW, 2);
    step(0, 1, LW, 3);
    chk("lw_wb", {reg_write, mem_to_reg, instr_done}, 3'b111);
    step(0, 1, LW, 4);

    // SW with two stall cycles in MEMWR
    step(0, 1, SW, 0);
    step(0, 1, SW, 1);
    step(0, 1, SW, 2);
    step(0, 0, SW, 5);
    step(0, 0, SW, 5);
    mem_ready = 1'b1;
    #1;
    chk("sw_done", {mem_write, instr_done}, 2'b11);
    step(0, 1, SW, 5);

    // fetch stall, then BEQ, then J
    mem_ready = 1'b0;
    #1;
    chk("stall_irw", ir_write, 0);
    step(0, 0, BEQ, 0);
    step(0, 0, BEQ, 0);
    step(0, 0, BEQ, 0);
    step(0, 1, BEQ, 0);
    step(0, 1, BEQ, 1);
    chk("beq_ex", {branch, alu_op, pc_src}, 5'b1_01_01);
    step(0, 1, BEQ, 8);
    step(0, 1, JMP, 0);
    step(0, 1, JMP, 1);
    chk("j_ex", {pc_write, pc_src}, 3'b1_10);
    step(0, 1, JMP, 11);

    // illegal opcode
    step(0, 1, 6'h3f, 0);
    opcode = 6'h3f;
    #1;
    chk("illegal", illegal_op, 1);
    step(0, 1, 6'h3f, 1);
    step(0, 1, RT, 0);

    // reset while in RTYPEEX
    step(0, 1, RT, 1);
    rst = 1'b0;
    #1;
    chk("rt_ex", state, 6);
    step(1, 1, RT);
    step(0, 1, RT, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: op = 6'($urandom);
      endcase
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), op);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
